// File: rtl/core_mem_stage_if.sv
// -----------------------------------------------------------------------------
// core_mem_stage_if
// Bundles the controller handshake and the data-bus request/response signals
// used by the memory-access stage.
//   slave  : seen by core_mem_stage (responder to the controller, master of dmem)
//   master : seen by whoever drives the stage (controller + data-bus model)
// Signals:
//   mem_stage_valid/ready, addr, wdata, funct3, is_store : controller side
//   load_data, exc_misaligned                            : results to write-back
//   dmem_req_* / dmem_resp_*                             : word-aligned data bus
// -----------------------------------------------------------------------------
interface core_mem_stage_if #(
    parameter int XLEN = 32
);
    logic            mem_stage_valid;
    logic            mem_stage_ready;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [2:0]      funct3;
    logic            is_store;
    logic [XLEN-1:0] load_data;
    logic            exc_misaligned;
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_req_addr;
    logic            dmem_req_wen;
    logic [3:0]      dmem_req_wstrb;
    logic [XLEN-1:0] dmem_req_wdata;
    logic            dmem_resp_valid;
    logic [XLEN-1:0] dmem_resp_rdata;

    modport slave (
        input  mem_stage_valid, addr, wdata, funct3, is_store,
               dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
        output mem_stage_ready, load_data, exc_misaligned,
               dmem_req_valid, dmem_req_addr, dmem_req_wen,
               dmem_req_wstrb, dmem_req_wdata
    );

    modport master (
        output mem_stage_valid, addr, wdata, funct3, is_store,
               dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
        input  mem_stage_ready, load_data, exc_misaligned,
               dmem_req_valid, dmem_req_addr, dmem_req_wen,
               dmem_req_wstrb, dmem_req_wdata
    );
endinterface

// File: rtl/core_mem_stage.sv
// -----------------------------------------------------------------------------
// core_mem_stage
// Memory-access stage of the multi-cycle RV32 core. Accepts one request from
// the controller, issues one word-aligned data-bus transaction, formats store
// strobes/data or extracts and extends load data, then pulses mem_stage_ready
// for one cycle.
// Ports:
//   clk   : core clock
//   rst_n : synchronous active-low reset
//   mif   : core_mem_stage_if.slave (controller handshake + data bus)
// Configuration:
//   CORE_MEM_MISALIGN_TRAP_EN : when defined, misaligned H/W accesses skip the
//   bus and complete with exc_misaligned = 1; otherwise they are forced aligned.
// -----------------------------------------------------------------------------
module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    core_mem_stage_if.slave    mif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Select the addressed byte/halfword of the read word and extend it.
    // funct3[2] set means zero-extend; size 1x is a full word.
    function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3[1:0])
            2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    state_e          state_q, state_d;
    logic            ready_q, ready_d;
    logic            req_valid_q, req_valid_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            req_wen_q, req_wen_d;
    logic [3:0]      req_wstrb_q, req_wstrb_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic            exc_q, exc_d;
    logic [1:0]      lane_q, lane_d;
    logic [2:0]      f3_q, f3_d;
    logic            is_store_q, is_store_d;

    logic [1:0]      lane_s;
    logic [3:0]      strb_s;
    logic [XLEN-1:0] wdata_s;
    logic            trap_s;

    // Lane, strobe and replicated store data from the incoming request;
    // lane bits below the access size are dropped, which forces alignment.
    always_comb begin
        lane_s  = 2'b00;
        strb_s  = 4'b1111;
        wdata_s = mif.wdata;
        case (mif.funct3[1:0])
            2'b00: begin
                lane_s  = mif.addr[1:0];
                strb_s  = 4'b0001 << mif.addr[1:0];
                wdata_s = {4{mif.wdata[7:0]}};
            end
            2'b01: begin
                lane_s  = {mif.addr[1], 1'b0};
                strb_s  = 4'b0011 << {mif.addr[1], 1'b0};
                wdata_s = {2{mif.wdata[15:0]}};
            end
            default: begin
                lane_s  = 2'b00;
                strb_s  = 4'b1111;
                wdata_s = mif.wdata;
            end
        endcase
    end

`ifdef CORE_MEM_MISALIGN_TRAP_EN
    // A misaligned request completes immediately without touching the bus.
    always_comb begin
        trap_s = 1'b0;
        if (mif.funct3[1:0] == 2'b00) begin
            trap_s = 1'b0;
        end else if (mif.funct3[1:0] == 2'b01) begin
            trap_s = mif.addr[0];
        end else begin
            trap_s = (mif.addr[1:0] != 2'b00);
        end
    end
`else
    assign trap_s = 1'b0;
`endif

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;
        load_data_d = load_data_q;
        exc_d       = 1'b0;
        lane_d      = lane_q;
        f3_d        = f3_q;
        is_store_d  = is_store_q;
        case (state_q)
            IDLE: begin
                if (mif.mem_stage_valid && trap_s) begin
                    state_d = DONE;
                    exc_d   = 1'b1;
                end else if (mif.mem_stage_valid) begin
                    state_d     = REQ;
                    lane_d      = lane_s;
                    f3_d        = mif.funct3;
                    is_store_d  = mif.is_store;
                    req_addr_d  = {mif.addr[XLEN-1:2], 2'b00};
                    req_wen_d   = mif.is_store;
                    req_wstrb_d = mif.is_store ? strb_s : 4'b0000;
                    req_wdata_d = mif.is_store ? wdata_s : 32'h0000_0000;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mif.dmem_req_ready) begin
                    state_d = RESP;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                if (mif.dmem_resp_valid) begin
                    state_d = DONE;
                    if (!is_store_q) begin
                        load_data_d = fmt_load(mif.dmem_resp_rdata, lane_q, f3_q);
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the state being entered.
        ready_d     = (state_d == DONE);
        req_valid_d = (state_d == REQ);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'h0000_0000;
            req_wen_q   <= 1'b0;
            req_wstrb_q <= 4'b0000;
            req_wdata_q <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
            exc_q       <= 1'b0;
            lane_q      <= 2'b00;
            f3_q        <= 3'b000;
            is_store_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wstrb_q <= req_wstrb_d;
            req_wdata_q <= req_wdata_d;
            load_data_q <= load_data_d;
            exc_q       <= exc_d;
            lane_q      <= lane_d;
            f3_q        <= f3_d;
            is_store_q  <= is_store_d;
        end
    end

    assign mif.mem_stage_ready = ready_q;
    assign mif.dmem_req_valid  = req_valid_q;
    assign mif.dmem_req_addr   = req_addr_q;
    assign mif.dmem_req_wen    = req_wen_q;
    assign mif.dmem_req_wstrb  = req_wstrb_q;
    assign mif.dmem_req_wdata  = req_wdata_q;
    assign mif.load_data       = load_data_q;
    assign mif.exc_misaligned  = exc_q;

endmodule

// File: doc/core_mem_stage.md
# core_mem_stage

Memory-access stage of the multi-cycle RV32 core. It is the responder to the core controller's `mem_stage_valid`/`mem_stage_ready` handshake. On each request it:
- issues one word-aligned transaction on the data bus;
- formats store data and byte strobes, or extracts and sign/zero-extends load data;
- returns `mem_stage_ready` for exactly one cycle when the result is final.

## Interface
Parameters:
- `XLEN`, 32, data/address width (only 32 supported)

Ports (clock and reset first). One clock; reset is synchronous and active-low.
- `clk`  in  1  core clock
- `rst_n`  in  1  synchronous active-low reset
- `mem_stage_valid`  in  1  controller request; held high until `mem_stage_ready` is seen
- `mem_stage_ready`  out  1  one-cycle completion pulse
- `addr`  in  32  effective address from EXEC
- `wdata`  in  32  store source (rs2)
- `funct3`  in  3  access size/sign
- `is_store`  in  1  1 = store, 0 = load
- `load_data`  out  32  extended load result, for write-back
- `exc_misaligned`  out  1  misaligned-access flag; valid while `mem_stage_ready` = 1
- `dmem_req_valid`  out  1  bus request valid
- `dmem_req_ready`  in  1  bus accepts request
- `dmem_req_addr`  out  32  `{addr[31:2],2'b00}`
- `dmem_req_wen`  out  1  write enable
- `dmem_req_wstrb`  out  4  byte strobes
- `dmem_req_wdata`  out  32  lane-replicated store data
- `dmem_resp_valid`  in  1  response/ack for both loads and stores
- `dmem_resp_rdata`  in  32  read word

## Operation
- **FSM states:** IDLE, REQ, RESP, DONE.
- **IDLE → REQ** when `mem_stage_valid` = 1.
  - `addr`, `wdata`, `funct3` and `is_store` are captured into registers on this transition.
  - All downstream outputs are driven from these captured values.
- **REQ:** `dmem_req_valid` = 1 with stable payload. → RESP on `dmem_req_ready` = 1.
- **RESP:** waits for `dmem_resp_valid`.
  - On a load, the formatted word is registered into `load_data`.
  - → DONE.
- **DONE:** `mem_stage_ready` = 1 for one cycle, unconditionally → IDLE.
  - The controller leaves MEM on this edge, so `valid` is low in the following IDLE cycle.
  - No second transaction is started.
- **Size decode** (`funct3`):
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - 011/110/111 are treated as W.
  - Stores ignore `funct3[2]`.
- **Store strobes:**
  - SB: `4'b0001 << addr[1:0]`
  - SH: `4'b0011 << {addr[1],1'b0}`
  - SW: `4'b1111`
- **Store data:** SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`.
- **Bus controls per access type:**
  - Loads: `dmem_req_wen` = 0, `dmem_req_wstrb` = 0.
  - Stores: `load_data` is unchanged.
- **Load extraction:**
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend.
- **Data holding:**
  - `load_data` holds its value until the next load completes.
  - Request payload outputs hold their last values when `dmem_req_valid` = 0.
- **Protocol violation:** if `mem_stage_valid` drops mid-transaction, the transaction still completes and DONE still pulses.

## Timing
- **Reset:** while `rst_n` = 0 at a rising edge:
  - state goes to IDLE;
  - `mem_stage_ready`, `dmem_req_valid`, `dmem_req_wen` and `exc_misaligned` = 0;
  - `dmem_req_wstrb`, `dmem_req_addr`, `dmem_req_wdata` and `load_data` = 0.
- **Reset mid-transaction:** the bus request is abandoned, and a late `dmem_resp_valid` is ignored in IDLE.
- **Latency:** minimum 3 cycles from `mem_stage_valid` sampled in IDLE to `mem_stage_ready` (REQ, RESP, DONE, each 1 cycle). Each bus stall adds 1 cycle.
- **Same-cycle ready/response:** `dmem_resp_valid` is only honoured in RESP. A response coinciding with `dmem_req_ready` in REQ is not legal on this bus.
- **Output timing:** `load_data` is valid in DONE, coincident with `mem_stage_ready`, which is the cycle the controller asserts `reg_d_en`.
- **Registered outputs:** all outputs are registered; there is no combinational path from `dmem_*` inputs to outputs.

## Configuration
- **`CORE_MEM_MISALIGN_TRAP_EN` defined:**
  - H/HU/SH with `addr[0]` = 1, or W/SW with `addr[1:0]` ≠ 0, is misaligned.
  - The FSM goes IDLE → DONE directly, with no bus request.
  - `exc_misaligned` = 1 during that DONE cycle, and `load_data` is unchanged.
- **Not defined:**
  - `exc_misaligned` is tied 0.
  - Misaligned accesses are forced aligned: the offending low address bits are treated as 0 for lane selection and strobes.

## Test plan
- **LW** `addr` = 0x1000, bus returns 0xDEADBEEF with zero wait states → `dmem_req_addr` = 0x1000, `wen` = 0. `ready` pulses exactly 3 cycles after `valid`, with `load_data` = 0xDEADBEEF.
- **LB/LBU** `addr` = 0x1003, rdata = 0x80FF_0000:
  - LB → `load_data` = 0xFFFFFF80;
  - LBU → `load_data` = 0x00000080.
- **SH** `addr` = 0x2002, `wdata` = 0x1234ABCD → `wstrb` = 4'b1100, `wdata` out = 0xABCDABCD, `wen` = 1. `load_data` is unchanged.
- **Stalls:** `dmem_req_ready` low for 2 cycles and response delayed 3 cycles → `dmem_req_valid` and payload are stable throughout, and `ready` arrives at cycle 8 as a single pulse.
- **Reset:** `rst_n` asserted in RESP → next cycle all outputs are 0 and state is IDLE. A subsequent `dmem_resp_valid` produces no `ready`.
- **Misaligned** LW `addr` = 0x1001:
  - with the macro: no `dmem_req_valid`, and `ready` plus `exc_misaligned` arrive 1 cycle after `valid`;
  - without the macro: the request goes to 0x1000 with a normal LW result.
